// File: rtl/grp_writer_pkg.sv
// Shared constants for the telemetry path: receiver word layout, buffer
// address width and the group-writer FSM encoding. The receiver and the
// frame former import the same package so the field positions agree.
package grp_writer_pkg;

  // Receiver word layout: [15:12] tag, [11:0] sample.
  localparam int WORD_W     = 16;
  localparam int TAG_W      = 4;
  localparam int SAMPLE_W   = 12;
  localparam int TAG_MSB    = 15;
  localparam int TAG_LSB    = 12;
  localparam int SAMPLE_MSB = 11;
  localparam int SAMPLE_LSB = 0;

  // Group buffers hold at most 1024 words, so 10 address bits suffice.
  localparam int ADDR_W        = 10;
  localparam int GROUP_LEN_MAX = 1 << ADDR_W;

  // Drop counter width; it saturates rather than wrapping.
  localparam int DROP_W = 8;

  // Tag value that marks the first word of a group.
  localparam logic [TAG_W-1:0] SYNC_TAG_DEFAULT = 4'hF;

  // Group-writer FSM encoding, also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } wr_state_e;

  // Extract the tag field of a receiver word.
  function automatic logic [TAG_W-1:0] word_tag(input logic [WORD_W-1:0] w);
    return w[TAG_MSB:TAG_LSB];
  endfunction

  // Extract the sample field of a receiver word.
  function automatic logic [SAMPLE_W-1:0] word_sample(input logic [WORD_W-1:0] w);
    return w[SAMPLE_MSB:SAMPLE_LSB];
  endfunction

endpackage

// File: rtl/grp_writer_edge_det.sv
// Toggle detector for the reader bank-select line. Keeps a registered copy
// of the input and flags any cycle where the live value differs from it,
// so the consumer sees the change in the same cycle the line moves.
module edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic toggle_o
);

  logic sig_q;

  // Registered copy of the monitored line; cleared to 0 on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  // High for exactly the cycle in which the line differs from its last value.
  assign toggle_o = sig_i ^ sig_q;

endmodule

// File: rtl/grp_writer.sv
// Group writer: fills the ping-pong bank the frame former is not reading
// with 12-bit samples, tracks group boundaries via sync-tagged words, hands
// a full group over when the reader switches banks, and counts words lost
// when the reader falls behind. All outputs are registered, so every write
// appears one cycle after the accepted input word.
module grp_writer
  import grp_writer_pkg::*;
#(
  // Words per group; legal range 2..1024 so the pointer fits ADDR_W bits.
  parameter int               GROUP_LEN = 1024,
  parameter logic [TAG_W-1:0] SYNC_TAG  = SYNC_TAG_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WORD_W-1:0]   iWord,
  input  logic                iValid,
  input  logic                iSwitch,
  output logic [ADDR_W-1:0]   oWrAddr,
  output logic [SAMPLE_W-1:0] oWrData,
  output logic                oWe0,
  output logic                oWe1,
  output logic                oGroupReady,
  output logic [DROP_W-1:0]   oDropCnt,
  output logic [1:0]          oState
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GROUP_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  // Architectural state.
  wr_state_e            state_q, state_d;
  logic                 bank_q, bank_d;
  logic [ADDR_W-1:0]    wptr_q, wptr_d;
  logic                 ready_q, ready_d;
  logic [DROP_W-1:0]    drop_q, drop_d;

  // Registered write port.
  logic                 we0_q, we0_d;
  logic                 we1_q, we1_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [SAMPLE_W-1:0]  data_q, data_d;

  // Per-cycle decode.
  logic                 sw_toggle;
  logic                 is_sync;
  logic                 wr_en;
  logic                 wr_bank;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 drop_evt;

  edge_det u_sw_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .sig_i    (iSwitch),
    .toggle_o (sw_toggle)
  );

  assign is_sync = iValid && (word_tag(iWord) == SYNC_TAG);

  // Next-state decode: group tracking, bank selection, write request and
  // drop events. The bank written is always the complement of the bank the
  // reader holds, taken from the live iSwitch whenever a re-bank happens.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    wptr_d   = wptr_q;
    ready_d  = ready_q;
    drop_d   = drop_q;
    we0_d    = 1'b0;
    we1_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_en    = 1'b0;
    wr_bank  = bank_q;
    wr_addr  = wptr_q;
    drop_evt = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        // Words before the first sync are noise, not drops.
        if (is_sync) begin
          bank_d  = ~iSwitch;
          wr_en   = 1'b1;
          wr_bank = ~iSwitch;
          wr_addr = '0;
          wptr_d  = ADDR_ONE;
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        if (sw_toggle) begin
          // Reader ran dry mid-group: restart in the newly free bank.
          // A word arriving in the same cycle opens the new group.
          drop_evt = 1'b1;
          bank_d   = ~iSwitch;
          if (iValid) begin
            wr_en   = 1'b1;
            wr_bank = ~iSwitch;
            wr_addr = '0;
            wptr_d  = ADDR_ONE;
          end else begin
            wptr_d  = '0;
          end
        end else if (is_sync && (wptr_q != '0)) begin
          // Resync: abandon the partial group and restart at address 0
          // in the same bank. Takes priority over the last-address rule.
          drop_evt = 1'b1;
          wr_en    = 1'b1;
          wr_addr  = '0;
          wptr_d   = ADDR_ONE;
        end else if (iValid) begin
          wr_en = 1'b1;
          if (wptr_q == LAST_ADDR) begin
            wptr_d  = '0;
            ready_d = 1'b1;
            state_d = ST_FULL;
          end else begin
            wptr_d  = wptr_q + ADDR_ONE;
          end
        end
      end

      ST_FULL: begin
        if (sw_toggle) begin
          // Reader took the full group; the other bank is now free.
          bank_d  = ~iSwitch;
          ready_d = 1'b0;
          state_d = ST_FILL;
          if (iValid) begin
            wr_en   = 1'b1;
            wr_bank = ~iSwitch;
            wr_addr = '0;
            wptr_d  = ADDR_ONE;
          end else begin
            wptr_d  = '0;
          end
        end else if (iValid) begin
          // Nowhere to put the word until the reader switches.
          drop_evt = 1'b1;
        end
      end

      default: begin
        state_d = ST_HUNT;
        wptr_d  = '0;
        ready_d = 1'b0;
      end
    endcase

    if (wr_en) begin
      we0_d  = ~wr_bank;
      we1_d  =  wr_bank;
      addr_d = wr_addr;
      data_d = word_sample(iWord);
    end

    if (drop_evt && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // FSM, pointer, counter and registered write port; async reset so the
  // write enables fall the moment reset_n goes low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HUNT;
      bank_q  <= 1'b0;
      wptr_q  <= '0;
      ready_q <= 1'b0;
      drop_q  <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      wptr_q  <= wptr_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      we0_q   <= we0_d;
      we1_q   <= we1_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign oWrAddr     = addr_q;
  assign oWrData     = data_q;
  assign oWe0        = we0_q;
  assign oWe1        = we1_q;
  assign oGroupReady = ready_q;
  assign oDropCnt    = drop_q;
  assign oState      = state_q;

endmodule

// File: tb/tb_grp_writer.sv
// Bench for grp_writer: directed scenarios followed by random traffic. The
// driver steps a behavioural model (phase / bank / word count / drop tally)
// and queues every write it predicts; a separate monitor pops and compares
// whenever the DUT raises a write enable.
module tb_grp_writer;

  localparam int GLEN = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] iWord = 16'h0;
  logic        iValid = 1'b0;
  logic        iSwitch = 1'b0;
  logic [9:0]  oWrAddr;
  logic [11:0] oWrData;
  logic        oWe0, oWe1, oGroupReady;
  logic [7:0]  oDropCnt;
  logic [1:0]  oState;

  grp_writer #(.GROUP_LEN(GLEN), .SYNC_TAG(4'hF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .iWord       (iWord),
    .iValid      (iValid),
    .iSwitch     (iSwitch),
    .oWrAddr     (oWrAddr),
    .oWrData     (oWrData),
    .oWe0        (oWe0),
    .oWe1        (oWe1),
    .oGroupReady (oGroupReady),
    .oDropCnt    (oDropCnt),
    .oState      (oState)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bank;
    int          addr;
    logic [11:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model: 0 = hunting, 1 = filling, 2 = full.
  int  m_phase;
  bit  m_bank;
  int  m_cnt;
  int  m_drop;
  bit  m_prev_sw;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, req, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase   = 0;
    m_bank    = 1'b0;
    m_cnt     = 0;
    m_drop    = 0;
    m_prev_sw = 1'b0;
  endfunction

  function automatic void model_write(int a, logic [15:0] w);
    wr_t e;
    e.bank = m_bank;
    e.addr = a;
    e.data = w[11:0];
    exp_q.push_back(e);
  endfunction

  // One clock of input applied to the model.
  function automatic void model_step(bit v, logic [15:0] w, bit sw);
    bit toggled = (sw != m_prev_sw);
    bit sync    = v && (w[15:12] == 4'hF);
    m_prev_sw = sw;
    if (m_phase == 0) begin
      if (sync) begin
        m_bank = !sw;
        model_write(0, w);
        m_cnt   = 1;
        m_phase = 1;
      end
    end else begin
      if (toggled) begin
        if (m_phase == 1) m_drop++;   // reader ran dry; partial group lost
        m_bank  = !sw;
        m_cnt   = 0;
        m_phase = 1;
      end else if (m_phase == 1 && sync && m_cnt != 0) begin
        m_cnt = 0;                    // resync restarts the group
        m_drop++;
      end
      if (m_phase == 2) begin
        if (v) m_drop++;
      end else if (v) begin
        model_write(m_cnt, w);
        m_cnt++;
        if (m_cnt == GLEN) m_phase = 2;
      end
    end
    if (m_drop > 255) m_drop = 255;
  endfunction

  // Check the outputs produced by the previous cycle, then drive this one.
  task automatic cyc(bit v, logic [15:0] w, bit sw);
    @(negedge clk);
    chk("state", int'(oState), m_phase);
    chk("group_ready", int'(oGroupReady), (m_phase == 2) ? 1 : 0);
    chk("drop_cnt", int'(oDropCnt), m_drop);
    iValid  = v;
    iWord   = w;
    iSwitch = sw;
    model_step(v, w, sw);
  endtask

  task automatic do_reset(bit sw);
    @(negedge clk);
    reset_n = 1'b0;
    iValid  = 1'b0;
    iSwitch = sw;
    #1;
    chk("rst_we0", int'(oWe0), 0);
    chk("rst_we1", int'(oWe1), 0);
    chk("rst_state", int'(oState), 0);
    chk("rst_ready", int'(oGroupReady), 0);
    chk("rst_drop", int'(oDropCnt), 0);
    model_reset();
    // Sync words while held in reset must not start anything.
    repeat (2) begin
      @(negedge clk);
      iValid = 1'b1;
      iWord  = 16'hF0F0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    iValid  = 1'b0;
    model_step(1'b0, 16'h0, sw);
  endtask

  // Monitor: compare every write the DUT presents against the queue.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (oWe0 && oWe1) begin
      checks++;
      failures++;
      $display("FAIL both_we: oWe0=1 oWe1=1 required at most one at t=%0t", $time);
    end else if (oWe0 || oWe1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: bank=%0d addr=%0d data=%03h, none required at t=%0t",
                 oWe1, oWrAddr, oWrData, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_bank", int'(oWe1), int'(e.bank));
        chk("wr_addr", int'(oWrAddr), e.addr);
        chk("wr_data", int'(oWrData), int'(e.data));
        $display("wr bank=%0d addr=%0d data=%03h", oWe1, oWrAddr, oWrData);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          sw;
    bit          v;
    logic [3:0]  tag;
    logic [15:0] w;

    model_reset();
    sw = 1'b0;
    do_reset(sw);

    // First group lands in bank 1 (reader on bank 0).
    cyc(1'b1, 16'hF123, sw);
    cyc(1'b1, 16'h0456, sw);
    cyc(1'b1, 16'h0789, sw);
    cyc(1'b1, 16'h0DEF, sw);
    cyc(1'b0, 16'h0000, sw);
    chk("ready_after_fill", int'(oGroupReady), 1);

    // Words arriving while full are dropped.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0100 + 16'(i), sw);
    cyc(1'b0, 16'h0000, sw);
    chk("drop_after_5", int'(oDropCnt), 5);

    // Toggle with a word in the same cycle: written at addr 0 of bank 0.
    sw = 1'b1;
    cyc(1'b1, 16'h0ABC, sw);
    cyc(1'b0, 16'h0000, sw);
    chk("ready_cleared", int'(oGroupReady), 0);
    chk("state_fill_after_switch", int'(oState), 1);

    // Resync at word 2: back to addr 0, then addr 1, same bank.
    cyc(1'b1, 16'h0111, sw);
    cyc(1'b1, 16'hF222, sw);
    cyc(1'b1, 16'h0333, sw);
    cyc(1'b0, 16'h0000, sw);
    chk("drop_after_resync", int'(oDropCnt), 6);

    // Complete the group, then saturate the drop counter.
    cyc(1'b1, 16'h0444, sw);
    cyc(1'b1, 16'h0555, sw);
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'h0666, sw);
    cyc(1'b0, 16'h0000, sw);
    chk("drop_saturated", int'(oDropCnt), 255);

    // Fresh start, then reset in the middle of a burst.
    sw = 1'b1;
    do_reset(sw);
    cyc(1'b1, 16'hF100, sw);
    cyc(1'b1, 16'h0101, sw);
    cyc(1'b1, 16'h0102, sw);
    do_reset(sw);
    for (int i = 0; i < 5; i++) cyc(1'b1, {4'h3, 12'($urandom)}, sw);
    cyc(1'b0, 16'h0000, sw);
    chk("hunt_after_reset", int'(oState), 0);

    // Random traffic: mostly back-to-back words, occasional syncs,
    // reader switches and resets.
    for (int n = 0; n < 1500; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      tag = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      w   = {tag, 12'($urandom)};
      if ($urandom_range(0, 24) == 0) sw = !sw;
      if ($urandom_range(0, 399) == 0) do_reset(sw);
      else cyc(v, w, sw);
    end

    repeat (3) cyc(1'b0, 16'h0000, sw);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
